// File: rtl/register_bank.sv
`default_nettype none
//============================================================================
// Module      : register_bank
// Description : Multi-entry register bank with one write port and two
//               registered read ports (A, B). Each read port also drives a
//               bitwise-complemented copy of its data. A per-entry dirty
//               vector records which entries were written since the last
//               reset or bulk clear.
//
// Ports       : clk        - single clock, all state updates on rising edge
//               reset      - synchronous active-high reset (highest priority)
//               clr        - synchronous bulk clear of all entries
//               we         - write enable
//               waddr      - write address
//               wdata      - write data
//               raddr_a/b  - read addresses, ports A and B
//               rdata_a/b  - registered read data
//               rdata_a_n/b_n - bitwise complement of rdata_a/b
//               dirty      - bit i set when entry i written since reset/clear
//
// Revision    : 1.0 - initial release
//============================================================================
module register_bank #(
    parameter int              WIDTH     = 8,
    parameter int              AW        = 3,
    parameter int              BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [AW-1:0]        raddr_a,
    input  logic [AW-1:0]        raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b,
    output logic [WIDTH-1:0]     rdata_a_n,
    output logic [WIDTH-1:0]     rdata_b_n,
    output logic [(2**AW)-1:0]   dirty
);

    localparam int c_DEPTH = 2**AW;

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [WIDTH-1:0]   r_rdata_a;
    logic [WIDTH-1:0]   r_rdata_b;
    logic [c_DEPTH-1:0] r_dirty;

    logic [WIDTH-1:0]   w_next_a;
    logic [WIDTH-1:0]   w_next_b;

    // Value each read register captures at the next edge. With forwarding
    // enabled, a colliding write supplies its data directly; otherwise the
    // array is read before the write lands, giving the pre-write contents.
    generate
        if (BYPASS != 0) begin : g_bypass
            always_comb begin
                w_next_a = r_mem[raddr_a];
                w_next_b = r_mem[raddr_b];
                if (we && (waddr == raddr_a)) begin
                    w_next_a = wdata;
                end
                if (we && (waddr == raddr_b)) begin
                    w_next_b = wdata;
                end
            end
        end else begin : g_no_bypass
            always_comb begin
                w_next_a = r_mem[raddr_a];
                w_next_b = r_mem[raddr_b];
            end
        end
    endgenerate

    // Reset and clear have identical effect; reset outranks clear, and both
    // outrank a write, so a write in either cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
            r_rdata_a <= RESET_VAL;
            r_rdata_b <= RESET_VAL;
            r_dirty   <= '0;
        end else begin
            if (we) begin
                r_mem[waddr]   <= wdata;
                r_dirty[waddr] <= 1'b1;
            end
            r_rdata_a <= w_next_a;
            r_rdata_b <= w_next_b;
        end
    end

    // Complements derive from the registered data so they never lag it.
    assign rdata_a   = r_rdata_a;
    assign rdata_b   = r_rdata_b;
    assign rdata_a_n = ~r_rdata_a;
    assign rdata_b_n = ~r_rdata_b;
    assign dirty     = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
//============================================================================
// Module      : tb_register_bank
// Description : Self-checking bench for register_bank. Three instances share
//               one stimulus stream: [0] defaults (forwarding, reset 0x00),
//               [1] no forwarding, [2] forwarding with reset value 0xC3.
// Revision    : 1.0 - initial release
//============================================================================
module tb_register_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;

    logic [7:0] ra  [3];
    logic [7:0] rb  [3];
    logic [7:0] ran [3];
    logic [7:0] rbn [3];
    logic [7:0] dty [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(8), .AW(3), .BYPASS(1), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[0]), .rdata_b(rb[0]),
        .rdata_a_n(ran[0]), .rdata_b_n(rbn[0]), .dirty(dty[0]));

    register_bank #(.WIDTH(8), .AW(3), .BYPASS(0), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[1]), .rdata_b(rb[1]),
        .rdata_a_n(ran[1]), .rdata_b_n(rbn[1]), .dirty(dty[1]));

    register_bank #(.WIDTH(8), .AW(3), .BYPASS(1), .RESET_VAL(8'hC3)) dut2 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[2]), .rdata_b(rb[2]),
        .rdata_a_n(ran[2]), .rdata_b_n(rbn[2]), .dirty(dty[2]));

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; we = 1'b0;
        step();
        step();
        checks++;
        if (ra[0] !== 8'h00 || rb[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got a=%h b=%h want 00/00", ra[0], rb[0]);
        end
        checks++;
        if (ran[0] !== 8'hFF || rbn[0] !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rdata_n: got a=%h b=%h want FF/FF", ran[0], rbn[0]);
        end
        checks++;
        if (dty[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_dirty: got %h want 00", dty[0]);
        end
        checks++;
        if (ra[2] !== 8'hC3 || ran[2] !== 8'h3C || rbn[2] !== 8'h3C) begin
            errors++;
            $display("FAIL reset_val_c3: got a=%h an=%h bn=%h want C3/3C/3C", ra[2], ran[2], rbn[2]);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 3'd3; wdata = 8'h5A;
        step();
        we = 1'b0; raddr_a = 3'd3;
        step();
        checks++;
        if (ra[0] !== 8'h5A || ran[0] !== 8'hA5) begin
            errors++;
            $display("FAIL write_read: got a=%h an=%h want 5A/A5", ra[0], ran[0]);
        end
        checks++;
        if (dty[0] !== 8'h08) begin
            errors++;
            $display("FAIL write_dirty: got %h want 08", dty[0]);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 3'd2; wdata = 8'h11;
        step();
        we = 1'b1; waddr = 3'd2; wdata = 8'h77; raddr_a = 3'd2; raddr_b = 3'd2;
        step();
        checks++;
        if (ra[0] !== 8'h77 || rb[0] !== 8'h77) begin
            errors++;
            $display("FAIL bypass_on: got a=%h b=%h want 77/77", ra[0], rb[0]);
        end
        checks++;
        if (ra[1] !== 8'h11 || rb[1] !== 8'h11) begin
            errors++;
            $display("FAIL bypass_off: got a=%h b=%h want 11/11", ra[1], rb[1]);
        end
        we = 1'b0;
        step();
        checks++;
        if (ra[1] !== 8'h77 || rb[1] !== 8'h77) begin
            errors++;
            $display("FAIL bypass_off_next: got a=%h b=%h want 77/77", ra[1], rb[1]);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(8'h10 + i);
            step();
        end
        we = 1'b0; raddr_a = 3'd6; raddr_b = 3'd1;
        step();
        checks++;
        if (ra[0] !== 8'h16 || rb[0] !== 8'h11 || dty[0] !== 8'hFF) begin
            errors++;
            $display("FAIL fill: got a=%h b=%h dirty=%h want 16/11/FF", ra[0], rb[0], dty[0]);
        end
        clr = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'hEE; raddr_a = 3'd5;
        step();
        checks++;
        if (ra[0] !== 8'h00 || rb[0] !== 8'h00 || dty[0] !== 8'h00) begin
            errors++;
            $display("FAIL clr: got a=%h b=%h dirty=%h want 00/00/00", ra[0], rb[0], dty[0]);
        end
        clr = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            step();
            checks++;
            if (ra[0] !== 8'h00 || rb[0] !== 8'h00 || ra[2] !== 8'hC3 || dty[0] !== 8'h00) begin
                errors++;
                $display("FAIL clr_entry%0d: got a=%h b=%h c3a=%h dirty=%h want 00/00/C3/00",
                         i, ra[0], rb[0], ra[2], dty[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1; waddr = 3'd4; wdata = 8'h21; raddr_a = 3'd4;
        step();
        reset = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 8'h99; raddr_a = 3'd1;
        step();
        checks++;
        if (ra[0] !== 8'h00 || ran[0] !== 8'hFF || dty[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got a=%h an=%h dirty=%h want 00/FF/00", ra[0], ran[0], dty[0]);
        end
        checks++;
        if (ra[2] !== 8'hC3 || ran[2] !== 8'h3C || rb[2] !== 8'hC3 || rbn[2] !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_c3: got a=%h an=%h b=%h bn=%h want C3/3C/C3/3C",
                     ra[2], ran[2], rb[2], rbn[2]);
        end
        reset = 1'b0; we = 1'b0; raddr_a = 3'd1; raddr_b = 3'd4;
        step();
        checks++;
        if (ra[0] !== 8'h00 || rb[0] !== 8'h00 || ra[2] !== 8'hC3) begin
            errors++;
            $display("FAIL reset_discard: got a=%h b=%h c3a=%h want 00/00/C3", ra[0], rb[0], ra[2]);
        end
    endtask

    // Random traffic against an array-based model of each configuration.
    task automatic test_random();
        int         bp [3];
        logic [7:0] rv [3];
        logic [7:0] mem [3][8];
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        logic [7:0] ed [3];
        bp[0] = 1; bp[1] = 0; bp[2] = 1;
        rv[0] = 8'h00; rv[1] = 8'h00; rv[2] = 8'hC3;

        reset = 1'b1; clr = 1'b0; we = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) mem[k][j] = rv[k];
            ea[k] = rv[k]; eb[k] = rv[k]; ed[k] = 8'h00;
        end

        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 99) < 2);
            clr     = ($urandom_range(0, 99) < 4);
            we      = ($urandom_range(0, 99) < 55);
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 8'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));

            for (int k = 0; k < 3; k++) begin
                if (reset || clr) begin
                    for (int j = 0; j < 8; j++) mem[k][j] = rv[k];
                    ea[k] = rv[k]; eb[k] = rv[k]; ed[k] = 8'h00;
                end else begin
                    ea[k] = (bp[k] != 0 && we && waddr == raddr_a) ? wdata : mem[k][raddr_a];
                    eb[k] = (bp[k] != 0 && we && waddr == raddr_b) ? wdata : mem[k][raddr_b];
                    if (we) begin
                        mem[k][waddr] = wdata;
                        ed[k] = ed[k] | (8'h01 << waddr);
                    end
                end
            end

            step();

            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ra[k] !== ea[k] || rb[k] !== eb[k] || dty[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL rand_dut%0d cyc%0d: got a=%h b=%h dirty=%h want %h/%h/%h",
                             k, n, ra[k], rb[k], dty[k], ea[k], eb[k], ed[k]);
                end
                checks++;
                if (ran[k] !== ~ea[k] || rbn[k] !== ~eb[k]) begin
                    errors++;
                    $display("FAIL rand_n_dut%0d cyc%0d: got an=%h bn=%h want %h/%h",
                             k, n, ran[k], rbn[k], ~ea[k], ~eb[k]);
                end
            end
        end
        reset = 1'b0; clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per entry.
REQ-002 SHALL provide parameter AW, default 3, address bits; DEPTH = 2**AW entries.
REQ-003 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write contents.
REQ-004 SHALL provide parameter RESET_VAL, default 0, WIDTH-bit value loaded into every entry on reset/clear.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-007 SHALL have port clr  input  1  synchronous bulk clear of all entries.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port waddr  input  AW  write address.
REQ-010 SHALL have port wdata  input  WIDTH  write data.
REQ-011 SHALL have ports raddr_a, raddr_b  input  AW  read addresses, ports A and B.
REQ-012 SHALL have ports rdata_a, rdata_b  output  WIDTH  registered read data.
REQ-013 SHALL have ports rdata_a_n, rdata_b_n  output  WIDTH  bitwise complement of rdata_a/rdata_b.
REQ-014 SHALL have port dirty  output  DEPTH  bit i = entry i written since last reset/clear.

Function
REQ-015 SHALL write wdata into entry waddr at the rising edge when we=1, reset=0, clr=0.
REQ-016 SHALL register reads: rdata_x at edge N+1 reflects raddr_x sampled at edge N+1 (one-cycle latency, no combinational path from raddr to rdata).
REQ-017 SHALL, with BYPASS=1 and we=1 and waddr==raddr_x, load rdata_x with wdata at that edge.
REQ-018 SHALL, with BYPASS=0 and the same collision, load rdata_x with the entry's pre-write value.
REQ-019 SHALL keep rdata_x_n equal to ~rdata_x in every cycle, including the cycle after reset and after every update (no one-cycle lag).
REQ-020 SHALL allow raddr_a == raddr_b; both ports return identical data.
REQ-021 SHALL, when clr=1, set all entries to RESET_VAL, clear dirty to all zeros, and load rdata_a/rdata_b with RESET_VAL at that edge.
REQ-022 SHALL give clr priority over we: a write presented in a clr cycle is discarded and sets no dirty bit.
REQ-023 SHALL set dirty[waddr] at the edge a write commits; dirty bits are never cleared except by reset or clr.
REQ-024 SHALL hold all entries, rdata and dirty unchanged in cycles with we=0, clr=0, reset=0, apart from the read-register update of REQ-016.
REQ-025 SHALL treat all address values 0..DEPTH-1 as valid; no out-of-range case exists.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, set all entries to RESET_VAL, rdata_a/rdata_b to RESET_VAL, rdata_a_n/rdata_b_n to ~RESET_VAL, dirty to 0.
REQ-027 SHALL give reset priority over clr and we; a write coincident with reset is discarded.
REQ-028 SHALL take no action on reset between clock edges (synchronous only).

Verification (WIDTH=8, AW=3, RESET_VAL=0 unless stated)
REQ-029 SHALL cover: reset 2 cycles -> rdata_a=rdata_b=0x00, rdata_a_n=rdata_b_n=0xFF, dirty=0x00.
REQ-030 SHALL cover: write 0x5A to addr 3, next cycle raddr_a=3 -> rdata_a=0x5A, rdata_a_n=0xA5, dirty=0x08.
REQ-031 SHALL cover: BYPASS=1, addr 2 holds 0x11, write 0x77 to addr 2 with raddr_a=raddr_b=2 same cycle -> both rdata=0x77 after that edge; repeat with BYPASS=0 -> both 0x11, then 0x77 one cycle later.
REQ-032 SHALL cover: fill all 8 entries with 0x10+i, then clr=1 with we=1 waddr=5 wdata=0xEE -> all entries 0x00, dirty=0x00, entry 5 reads 0x00.
REQ-033 SHALL cover: reset asserted mid-sequence with we=1 -> write discarded, all outputs at reset values on the next edge; RESET_VAL=0xC3 variant -> rdata=0xC3, rdata_n=0x3C.
REQ-034 SHALL cover: random write/read traffic against a reference model, checking rdata_x_n==~rdata_x every cycle.
